// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch unit.
//               fetch_state_t : fetch FSM states (IDLE, REQ, DRAIN)
//               IR_RESET_WORD : ir_data value after reset, opcode 4'b1111,
//                               identical to the IR's own reset contents
//               PC_INC        : byte stride between sequential fetches
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] IR_RESET_WORD = 32'hF000_0000;
  localparam int          PC_INC        = 4;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Prefetch buffer, DEPTH entries of WIDTH bits, with push, pop
//               and flush. DEPTH must be a power of two and at least 2.
//               clk       in  rising-edge clock
//               rst       in  asynchronous active-high reset
//               push      in  write push_data (ignored when full)
//               push_data in  WIDTH-bit entry to store
//               pop       in  drop the head entry (ignored when empty)
//               flush     in  discard every entry; wins over push and pop
//               pop_data  out head entry (valid when not empty)
//               count     out number of stored entries
//               full      out count == DEPTH
//               empty     out count == 0
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = storage[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        storage[wr_ptr] <= push_data;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetch side of the instruction-register interface. Keeps the
//               fetch PC, prefetches words over a req/ack memory handshake
//               into a small buffer and hands one word per next_instr to the
//               IR: ir_data/instr_pc settle one cycle, then ldir pulses once.
//               clk        in  rising-edge clock
//               rst        in  asynchronous active-high reset
//               mem_req    out memory read request
//               mem_addr   out read address, held while mem_req and no ack
//               mem_ack    in  one-cycle ack, mem_rdata valid with it
//               mem_rdata  in  instruction word from memory
//               next_instr in  control unit asks for the next word
//               pc_load    in  redirect strobe
//               pc_new     in  redirect target
//               ir_data    out word for the IR data input
//               ldir       out IR load strobe
//               instr_pc   out byte address of the word on ir_data
//               busy       out delivery in flight (ldir not yet finished)
//               fifo_empty out prefetch buffer empty (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic              next_instr,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_new,
  output logic [31:0]       ir_data,
  output logic              ldir,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              busy,
  output logic              fifo_empty
);

  localparam int                CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);

  fetch_state_t        state;
  fetch_state_t        state_next;
  logic [ADDR_W-1:0]   fetch_pc;
  logic [ADDR_W-1:0]   fetch_pc_next;
  logic [ADDR_W-1:0]   req_addr;

  logic                buf_push;
  logic                buf_pop;
  logic [ADDR_W+31:0]  buf_head;
  logic [CNT_W-1:0]    buf_count;
  logic [CNT_W-1:0]    count_after;
  logic                buf_full;
  logic                buf_empty;

  // A word acked in the same cycle as a redirect belongs to the old stream.
  assign buf_push = (state == REQ) && mem_ack && !pc_load && !buf_full;
  // Requests that arrive while empty, busy or redirecting are dropped.
  assign buf_pop  = next_instr && !buf_empty && !busy && !pc_load;

  // Occupancy once the ack being taken this cycle has landed.
  assign count_after = buf_count + CNT_W'(1) - CNT_W'(buf_pop);

  assign mem_req  = (state == REQ) || (state == DRAIN);
  assign mem_addr = req_addr;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W + 32)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (buf_push),
    .push_data ({req_addr, mem_rdata}),
    .pop       (buf_pop),
    .flush     (pc_load),
    .pop_data  (buf_head),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      // While draining, the abandoned request's address must stay on the
      // bus until memory acks it, even though fetch_pc already points at
      // the redirect target.
      if (state_next != DRAIN) begin
        req_addr <= fetch_pc_next;
      end
    end
  end

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    unique case (state)
      IDLE: begin
        // Only one request is ever outstanding, so the credit test reduces
        // to the stored count; a redirect empties the buffer this cycle.
        if (pc_load || (buf_count < DEPTH_C)) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          if (pc_load) begin
            state_next = IDLE;
          end else begin
            fetch_pc_next = fetch_pc + ADDR_W'(PC_INC);
            state_next    = (count_after < DEPTH_C) ? REQ : IDLE;
          end
        end else if (pc_load) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (pc_load) begin
      fetch_pc_next = pc_new;
    end
  end

  // Delivery: data/address settle in the cycle after the pop, ldir rises
  // one cycle later so the edge-triggered IR samples stable data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_data  <= IR_RESET_WORD;
      instr_pc <= RESET_PC;
      busy     <= 1'b0;
      ldir     <= 1'b0;
    end else if (buf_pop) begin
      ir_data  <= buf_head[31:0];
      instr_pc <= buf_head[ADDR_W+31:32];
      busy     <= 1'b1;
      ldir     <= 1'b0;
    end else if (busy && !ldir) begin
      ldir <= 1'b1;
    end else if (ldir) begin
      ldir <= 1'b0;
      busy <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_empty <= 1'b1;
    end else begin
      fifo_empty <= (buf_count == '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Randomized bench for instr_fetch_unit. Acts as instruction
//               memory (word contents derived from the address) and as the
//               control unit, and predicts deliveries from a queue model of
//               the prefetched instruction stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  localparam int          ADDR_W   = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        next_instr;
  logic        pc_load;
  logic [31:0] pc_new;
  logic [31:0] ir_data;
  logic        ldir;
  logic [31:0] instr_pc;
  logic        busy;
  logic        fifo_empty;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W     (ADDR_W),
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .next_instr (next_instr),
    .pc_load    (pc_load),
    .pc_new     (pc_new),
    .ir_data    (ir_data),
    .ldir       (ldir),
    .instr_pc   (instr_pc),
    .busy       (busy),
    .fifo_empty (fifo_empty)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  // Reference model of the instruction stream.
  logic [31:0] m_pc;          // next sequential fetch address
  logic [31:0] m_ir_addr;     // address of the word expected on ir_data
  logic [31:0] m_ir_data;
  logic [31:0] m_stale_addr;  // address of a request abandoned by a redirect
  bit          m_stale;
  int          m_stage;       // cycles since the pop: 0 idle, 1 data, 2 ldir
  bit          m_empty;
  logic [31:0] q[$];
  int          n_deliv = 0;

  task automatic model_reset();
    m_pc         = RESET_PC;
    m_ir_addr    = RESET_PC;
    m_ir_data    = 32'hF000_0000;
    m_stale_addr = RESET_PC;
    m_stale      = 1'b0;
    m_stage      = 0;
    m_empty      = 1'b1;
    q.delete();
  endtask

  // Called at a falling edge: check outputs, drive inputs for the next
  // rising edge, advance the model, and move to the next falling edge.
  task automatic run_random(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check("busy", {31'b0, busy}, {31'b0, m_stage != 0});
      check("ldir", {31'b0, ldir}, {31'b0, m_stage == 2});
      check("ir_data", ir_data, m_ir_data);
      check("instr_pc", instr_pc, m_ir_addr);
      check("fifo_empty", {31'b0, fifo_empty}, {31'b0, m_empty});
      if (mem_req && !m_stale) check("credit", q.size(), q.size() < DEPTH ? q.size() : DEPTH - 1);

      pc_load = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 2))
        0:       pc_new = 32'h0000_0100;
        1:       pc_new = 32'hFFFF_FFFC;
        default: pc_new = $urandom & 32'hFFFF_FFFC;
      endcase
      next_instr = ($urandom_range(0, 9) < 4);
      mem_ack    = mem_req && ($urandom_range(0, 1) == 1);
      mem_rdata  = mem_ack ? mem_word(mem_addr) : $urandom;
      if (mem_ack) check("ack_addr", mem_addr, m_stale ? m_stale_addr : m_pc);

      m_empty = (q.size() == 0);
      if (next_instr && q.size() > 0 && m_stage == 0 && !pc_load) begin
        m_ir_addr = q.pop_front();
        m_ir_data = mem_word(m_ir_addr);
        m_stage   = 1;
        n_deliv++;
      end else if (m_stage == 1) begin
        m_stage = 2;
      end else if (m_stage == 2) begin
        m_stage = 0;
      end

      if (pc_load) begin
        if (mem_req && !mem_ack && !m_stale) begin
          m_stale      = 1'b1;
          m_stale_addr = m_pc;
        end
        if (mem_ack) m_stale = 1'b0;
        q.delete();
        m_pc = pc_new;
      end else if (mem_ack) begin
        if (!m_stale) begin
          q.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
        m_stale = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    rst        = 1'b1;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h0;
    next_instr = 1'b0;
    pc_load    = 1'b0;
    pc_new     = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);

    check("rst_ir_data", ir_data, 32'hF000_0000);
    check("rst_ldir", {31'b0, ldir}, 32'h0);
    check("rst_mem_req", {31'b0, mem_req}, 32'h0);
    check("rst_mem_addr", mem_addr, RESET_PC);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_fifo_empty", {31'b0, fifo_empty}, 32'h1);
    check("rst_instr_pc", instr_pc, RESET_PC);

    rst = 1'b0;
    @(negedge clk);
    check("rel_mem_req", {31'b0, mem_req}, 32'h1);
    check("rel_mem_addr", mem_addr, 32'h0);

    run_random(3000);

    // Reset during the ldir cycle.
    found = 1'b0;
    for (int k = 0; k < 500 && !found; k++) begin
      if (ldir) found = 1'b1;
      else run_random(1);
    end
    check("ldir_seen", {31'b0, found}, 32'h1);
    pc_load    = 1'b0;
    next_instr = 1'b0;
    mem_ack    = 1'b0;
    rst        = 1'b1;
    #1;
    check("mid_rst_ldir", {31'b0, ldir}, 32'h0);
    check("mid_rst_ir_data", ir_data, 32'hF000_0000);
    check("mid_rst_fifo_empty", {31'b0, fifo_empty}, 32'h1);
    check("mid_rst_busy", {31'b0, busy}, 32'h0);
    check("mid_rst_mem_req", {31'b0, mem_req}, 32'h0);
    check("mid_rst_instr_pc", instr_pc, RESET_PC);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    // Stray ack for the abandoned request: must not enter the buffer.
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_ack = 1'b0;
    check("post_rst_mem_req", {31'b0, mem_req}, 32'h1);
    check("post_rst_mem_addr", mem_addr, RESET_PC);
    check("post_rst_fifo_empty", {31'b0, fifo_empty}, 32'h1);

    run_random(3000);
    check("deliveries", {31'b0, n_deliv > 200}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
